// File: rtl/sram_like_responder_pkg.sv
// Shared types and helpers for the SRAM-like responder: size encodings,
// the response-queue entry layout and the byte write-enable decode.
package sram_like_responder_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Countdown width; holds LAT-1 plus up to 3 extra random cycles.
    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic             wr;
        logic             data_vld;
        logic [31:0]      data;
        logic [CNT_W-1:0] cnt;
    } resp_entry_t;

    function automatic logic [3:0] wen_decode(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SIZE_BYTE: return 4'b0001 << a;
            SIZE_HALF: return 4'b0011 << a;
            default:   return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/sram_resp_queue.sv
// In-order circular queue of outstanding responses with per-entry countdowns,
// one-cycle-late read data capture and a bypass for a head issued last cycle.
module sram_resp_queue
    import sram_like_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             push_wr,
    input  logic [CNT_W-1:0] push_cnt,
    input  logic [31:0]      ram_rdata,
    output logic [CW-1:0]    count,
    output logic             head_ready_c,
    output logic [31:0]      head_rdata_c
);

    resp_entry_t      q [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push_q;
    logic [PTR_W-1:0] push_idx_q;
    logic [DEPTH-1:0] occ;
    logic             byp;
    logic             pop;
    resp_entry_t      hd;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Occupancy per slot and head-response readiness.
    always_comb begin
        occ          = '0;
        hd           = q[head];
        byp          = push_q && (push_idx_q == head);
        head_ready_c = 1'b0;
        head_rdata_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ[i] = ((32'(i) + DEPTH - 32'(head)) % DEPTH) < 32'(count);
        end
        head_ready_c = (count != '0) && (hd.cnt == '0) && (hd.data_vld || hd.wr || byp);
        head_rdata_c = hd.wr ? 32'h0 : (byp ? ram_rdata : hd.data);
    end

    assign pop = head_ready_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            push_q     <= 1'b0;
            push_idx_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            push_q     <= push;
            push_idx_q <= tail;
            if (push) tail <= next_ptr(tail);
            if (pop)  head <= next_ptr(head);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (PTR_W'(i) == tail)) begin
                    q[i] <= '{wr: push_wr, data_vld: 1'b0, data: 32'h0, cnt: push_cnt};
                end else begin
                    if (occ[i] && (q[i].cnt != '0)) begin
                        q[i].cnt <= q[i].cnt - CNT_W'(1);
                    end
                    // RAM read data lands the cycle after issue.
                    if (push_q && (PTR_W'(i) == push_idx_q) && !q[i].wr) begin
                        q[i].data     <= ram_rdata;
                        q[i].data_vld <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sram_like_responder.sv
// Responder end of the SRAM-like req/addr_ok/data_ok interface in front of a
// synchronous RAM. Define SRAM_RAND_DELAY_EN for LFSR-driven stalls and extra latency.
module sram_like_responder
    import sram_like_responder_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned LAT    = 1,
    parameter int unsigned RAM_AW = 16,
    parameter logic [15:0] SEED   = 16'hACE1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       rdata,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    logic [CW-1:0]    count;
    logic             stall;
    logic [CNT_W-1:0] extra;
    logic             hs;
    logic             head_ready_c;
    logic [31:0]      head_rdata_c;
    logic             unused_ok;

`ifdef SRAM_RAND_DELAY_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr <= SEED;
        else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    assign stall = (lfsr[1:0] == 2'b11);
    assign extra = CNT_W'(lfsr[3:2]);
`else
    assign stall = 1'b0;
    assign extra = '0;
`endif

    assign unused_ok = ^{addr[31:RAM_AW+2], SEED};

    // Acceptance depends only on internal state, never on req.
    assign addr_ok   = !reset && (count < CW'(DEPTH)) && !stall;
    assign hs        = req && addr_ok;
    assign ram_en    = hs;
    assign ram_wen   = (hs && wr) ? wen_decode(size, addr[1:0]) : 4'b0000;
    assign ram_addr  = addr[RAM_AW+1:2];
    assign ram_wdata = wdata;

    sram_resp_queue #(.DEPTH(DEPTH)) u_queue (
        .clk          (clk),
        .reset        (reset),
        .push         (hs),
        .push_wr      (wr),
        .push_cnt     (CNT_W'(LAT - 1) + extra),
        .ram_rdata    (ram_rdata),
        .count        (count),
        .head_ready_c (head_ready_c),
        .head_rdata_c (head_rdata_c)
    );

    assign data_ok = head_ready_c;
    assign rdata   = head_ready_c ? head_rdata_c : 32'h0;

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench: one responder with LAT=1 and one with LAT=3, each with its own RAM model.
module tb_sram_like_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req1, req3, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;

    logic        addr_ok1, data_ok1, ram_en1;
    logic [31:0] rdata1, ram_wdata1, ram_rdata1;
    logic [3:0]  ram_wen1;
    logic [15:0] ram_addr1;

    logic        addr_ok3, data_ok3, ram_en3;
    logic [31:0] rdata3, ram_wdata3, ram_rdata3;
    logic [3:0]  ram_wen3;
    logic [15:0] ram_addr3;

    logic [31:0] mem1 [64];
    logic [31:0] mem3 [64];
    logic        unused_tb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign unused_tb = ^{ram_addr1[15:6], ram_addr3[15:6]};

    sram_like_responder #(.DEPTH(2), .LAT(1)) u1 (
        .clk(clk), .reset(reset), .req(req1), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok1), .data_ok(data_ok1), .rdata(rdata1), .ram_en(ram_en1), .ram_wen(ram_wen1),
        .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
    );

    sram_like_responder #(.DEPTH(2), .LAT(3)) u3 (
        .clk(clk), .reset(reset), .req(req3), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok3), .data_ok(data_ok3), .rdata(rdata3), .ram_en(ram_en3), .ram_wen(ram_wen3),
        .ram_addr(ram_addr3), .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3)
    );

    // Word i holds 0xA5A5_000i, except word 4 which holds 0x1234_5678.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem1[i] <= {16'hA5A5, 16'(i)};
            mem1[4] <= 32'h1234_5678;
        end else if (ram_en1) begin
            for (int b = 0; b < 4; b++)
                if (ram_wen1[b]) mem1[ram_addr1[5:0]][8*b +: 8] <= ram_wdata1[8*b +: 8];
            ram_rdata1 <= mem1[ram_addr1[5:0]];
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < 64; j++) mem3[j] <= {16'hA5A5, 16'(j)};
        end else if (ram_en3) begin
            for (int c = 0; c < 4; c++)
                if (ram_wen3[c]) mem3[ram_addr3[5:0]][8*c +: 8] <= ram_wdata3[8*c +: 8];
            ram_rdata3 <= mem3[ram_addr3[5:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        req1 = 1'b0; req3 = 1'b0; wr = 1'b0; size = 2'd2; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_addr_ok", 32'(addr_ok1), 32'd0);
        chk("rst_data_ok", 32'(data_ok1), 32'd0);
        chk("rst_rdata",   rdata1,        32'd0);
        chk("rst_ram_en",  32'(ram_en1),  32'd0);
        chk("rst_ram_wen", 32'(ram_wen1), 32'd0);
        chk("rst_addr_ok3", 32'(addr_ok3), 32'd0);
        reset = 1'b0;

        // Single read, LAT=1
        cyc(); req1 = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h10; #1;
        chk("rd_addr_ok",  32'(addr_ok1), 32'd1);
        chk("rd_ram_en",   32'(ram_en1),  32'd1);
        chk("rd_ram_addr", 32'(ram_addr1), 32'd4);
        chk("rd_ram_wen",  32'(ram_wen1), 32'd0);
        chk("rd_no_same_cycle", 32'(data_ok1), 32'd0);
        cyc(); req1 = 1'b0; #1;
        chk("rd_data_ok", 32'(data_ok1), 32'd1);
        chk("rd_rdata",   rdata1, 32'h1234_5678);
        cyc(); #1;
        chk("rd_done", 32'(data_ok1), 32'd0);

        // Byte write into lane 3 of word 4
        req1 = 1'b1; wr = 1'b1; size = 2'd0; addr = 32'h13; wdata = 32'hAB00_0000; #1;
        chk("bw_wen",  32'(ram_wen1), 32'b1000);
        chk("bw_addr", 32'(ram_addr1), 32'd4);
        chk("bw_wdata", ram_wdata1, 32'hAB00_0000);
        cyc(); req1 = 1'b0; wr = 1'b0; #1;
        chk("bw_data_ok", 32'(data_ok1), 32'd1);
        chk("bw_rdata",   rdata1, 32'd0);
        cyc(); req1 = 1'b1; size = 2'd2; addr = 32'h10; #1;
        cyc(); req1 = 1'b0; #1;
        chk("bw_readback", rdata1, 32'hAB34_5678);

        // Back-to-back reads 0x0, 0x4, 0x8
        cyc(); req1 = 1'b1; addr = 32'h0; #1;
        chk("b2b_hs0", 32'(addr_ok1), 32'd1);
        chk("b2b_idle", 32'(data_ok1), 32'd0);
        cyc(); addr = 32'h4; #1;
        chk("b2b_hs1", 32'(addr_ok1), 32'd1);
        chk("b2b_ok0", 32'(data_ok1), 32'd1);
        chk("b2b_d0",  rdata1, 32'hA5A5_0000);
        cyc(); addr = 32'h8; #1;
        chk("b2b_ok1", 32'(data_ok1), 32'd1);
        chk("b2b_d1",  rdata1, 32'hA5A5_0001);
        cyc(); req1 = 1'b0; #1;
        chk("b2b_ok2", 32'(data_ok1), 32'd1);
        chk("b2b_d2",  rdata1, 32'hA5A5_0002);
        cyc(); #1;
        chk("b2b_done", 32'(data_ok1), 32'd0);

        // Half write to upper half of word 15
        req1 = 1'b1; wr = 1'b1; size = 2'd1; addr = 32'h3E; wdata = 32'hBEEF_0000; #1;
        chk("hw_wen", 32'(ram_wen1), 32'b1100);
        cyc(); req1 = 1'b0; wr = 1'b0; size = 2'd2; #1;
        chk("hw_data_ok", 32'(data_ok1), 32'd1);

        // LAT=3, DEPTH=2, req held high
        cyc(); req3 = 1'b1; addr = 32'h20; #1;
        chk("full_t0_addr_ok", 32'(addr_ok3), 32'd1);
        cyc(); addr = 32'h24; #1;
        chk("full_t1_addr_ok", 32'(addr_ok3), 32'd1);
        chk("full_t1_data_ok", 32'(data_ok3), 32'd0);
        cyc(); addr = 32'h28; #1;
        chk("full_t2_addr_ok", 32'(addr_ok3), 32'd0);
        chk("full_t2_ram_en",  32'(ram_en3),  32'd0);
        chk("full_t2_data_ok", 32'(data_ok3), 32'd0);
        cyc(); #1;
        chk("full_t3_addr_ok", 32'(addr_ok3), 32'd0);
        chk("full_t3_data_ok", 32'(data_ok3), 32'd1);
        chk("full_t3_rdata",   rdata3, 32'hA5A5_0008);
        cyc(); #1;
        chk("full_t4_addr_ok", 32'(addr_ok3), 32'd1);
        chk("full_t4_data_ok", 32'(data_ok3), 32'd1);
        chk("full_t4_rdata",   rdata3, 32'hA5A5_0009);
        cyc(); req3 = 1'b0; #1;
        chk("full_t5_data_ok", 32'(data_ok3), 32'd0);
        chk("full_t5_addr_ok", 32'(addr_ok3), 32'd1);
        cyc(); #1;
        chk("full_t6_data_ok", 32'(data_ok3), 32'd0);
        cyc(); #1;
        chk("full_t7_data_ok", 32'(data_ok3), 32'd1);
        chk("full_t7_rdata",   rdata3, 32'hA5A5_000A);
        cyc(); #1;
        chk("full_t8_data_ok", 32'(data_ok3), 32'd0);

        // Reset with two outstanding reads
        req3 = 1'b1; addr = 32'h2C; #1;
        cyc(); addr = 32'h30; #1;
        cyc(); req3 = 1'b0; #1;
        chk("rr_full", 32'(addr_ok3), 32'd0);
        cyc();
        chk("rr_pre_data_ok", 32'(data_ok3), 32'd1);
        reset = 1'b1; #1;
        chk("rr_data_ok_drop", 32'(data_ok3), 32'd0);
        chk("rr_addr_ok_drop", 32'(addr_ok3), 32'd0);
        chk("rr_rdata_drop",   rdata3, 32'd0);
        cyc(); reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(); #1;
            chk("rr_no_stale", 32'(data_ok3), 32'd0);
        end
        req3 = 1'b1; addr = 32'h34; #1;
        chk("rr_addr_ok", 32'(addr_ok3), 32'd1);
        cyc(); req3 = 1'b0; #1;
        chk("rr_wait1", 32'(data_ok3), 32'd0);
        cyc(); #1;
        chk("rr_wait2", 32'(data_ok3), 32'd0);
        cyc(); #1;
        chk("rr_data_ok", 32'(data_ok3), 32'd1);
        chk("rr_rdata",   rdata3, 32'hA5A5_000D);
        cyc(); #1;
        chk("rr_done", 32'(data_ok3), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
